seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider. It is the inverse arithmetic companion to the team's ripple adders.
- Computes quotient and remainder one bit per clock using a trial subtraction, then shift.
- Sits beside the adder in the datapath as the DIV/MOD execution unit.
- Driven by the control unit through a start/done handshake.

---
 rtl/seq_divider_if.sv | 36 +++
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for the sequential divider.
// The control unit is the master; the divider is the slave.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// DIV/MOD execution unit driven through a start/done handshake.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  div
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] r, r_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] dvsr, dvsr_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] quo, quo_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic             dbz, dbz_nxt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             carry;
  logic             unused_msb;

  // Subtract by adding the inverted divisor with carry-in; carry out means no borrow.
  assign shifted = {r, q[WIDTH-1]};
  assign {carry, trial} = {1'b0, shifted}
                        + {1'b0, ~{1'b0, dvsr}}
                        + {{(WIDTH + 1){1'b0}}, 1'b1};
  assign unused_msb = trial[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      q     <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      q     <= q_nxt;
      dvsr  <= dvsr_nxt;
      cnt   <= cnt_nxt;
      quo   <= quo_nxt;
      rem   <= rem_nxt;
      dbz   <= dbz_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    q_nxt     = q;
    dvsr_nxt  = dvsr;
    cnt_nxt   = cnt;
    quo_nxt   = quo;
    rem_nxt   = rem;
    dbz_nxt   = dbz;
    unique case (state)
      IDLE: begin
        if (div.start) begin
          if (div.divisor != '0) begin
            dvsr_nxt  = div.divisor;
            r_nxt     = '0;
            q_nxt     = div.dividend;
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else begin
            quo_nxt   = '1;
            rem_nxt   = div.dividend;
            dbz_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (carry) begin
          r_nxt = trial[WIDTH-1:0];
          q_nxt = {q[WIDTH-2:0], 1'b1};
        end else begin
          r_nxt = shifted[WIDTH-1:0];
          q_nxt = {q[WIDTH-2:0], 1'b0};
        end
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          quo_nxt   = q_nxt;
          rem_nxt   = r_nxt;
          dbz_nxt   = 1'b0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign div.busy        = (state == RUN);
  assign div.done        = (state == DONE);
  assign div.quotient    = quo;
  assign div.remainder   = rem;
  assign div.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed vectors, protocol,
// reset-abort and a random sweep against a q=a/b, r=a%b model.
module tb_seq_divider;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) dif();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (dif.slave)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           cyc;
    int           nb;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((dif.busy || dif.done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic div_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er);
    exp_t e;
    @(negedge clk);
    wait_idle();
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    e.a   = a;
    e.b   = b;
    e.q   = eq;
    e.r   = er;
    e.z   = (b == '0);
    e.cyc = (b == '0) ? cyc + 1 : cyc + 1 + W;
    e.nb  = (b == '0) ? 0 : W;
    sb.push_back(e);
    @(negedge clk);
    dif.start    = 1'b0;
    dif.dividend = ~a;
    dif.divisor  = ~b;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, dif.busy, 0);
    chk({tag, "_done"}, dif.done, 0);
    chk({tag, "_q"}, dif.quotient, 0);
    chk({tag, "_r"}, dif.remainder, 0);
    chk({tag, "_dbz"}, dif.div_by_zero, 0);
  endtask

  // Monitor: pops the scoreboard on every done pulse
  initial begin
    int bcnt = 0;
    bit pv = 1'b0;
    logic [W-1:0] pq = '0;
    logic [W-1:0] pr = '0;
    logic pz = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0;
        pv = 1'b0;
      end else if (dif.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("quotient", dif.quotient, e.q);
          chk("remainder", dif.remainder, e.r);
          chk("div_by_zero", dif.div_by_zero, e.z);
          chk("latency", cyc, e.cyc);
          chk("busy_cycles", bcnt, e.nb);
          chk("busy_in_done", dif.busy, 0);
          if (!e.z) begin
            chk("invariant",
                32'(dif.quotient) * 32'(e.b) + 32'(dif.remainder),
                32'(e.a));
            chk("rem_lt_div", 32'(dif.remainder < e.b), 1);
          end
        end
        bcnt = 0;
        pq = dif.quotient;
        pr = dif.remainder;
        pz = dif.div_by_zero;
        pv = 1'b1;
      end else begin
        if (dif.busy) bcnt++;
        if (pv)
          chk("outputs_held", {dif.div_by_zero, dif.remainder, dif.quotient},
              {pz, pr, pq});
        pq = dif.quotient;
        pr = dif.remainder;
        pz = dif.div_by_zero;
        pv = 1'b1;
      end
    end
  end

  initial begin
    int acc;
    int n;
    logic [W-1:0] a, b;
    exp_t e;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;

    repeat (2) @(negedge clk);
    #2;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("post_reset");

    div_op(8'd100, 8'd7,   8'd14,  8'd2);
    div_op(8'd255, 8'd1,   8'd255, 8'd0);
    div_op(8'd255, 8'd255, 8'd1,   8'd0);
    div_op(8'd5,   8'd9,   8'd0,   8'd5);
    div_op(8'd0,   8'd3,   8'd0,   8'd0);
    div_op(8'd200, 8'd0,   8'd255, 8'd200);
    div_op(8'd10,  8'd3,   8'd3,   8'd1);
    div_op(8'd1,   8'd1,   8'd1,   8'd0);
    div_op(8'd254, 8'd127, 8'd2,   8'd0);
    div_op(8'd128, 8'd2,   8'd64,  8'd0);

    // start during busy must be ignored
    div_op(8'd100, 8'd7, 8'd14, 8'd2);
    repeat (2) @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 8'd50;
    dif.divisor  = 8'd5;
    @(negedge clk);
    dif.start    = 1'b0;
    dif.dividend = 8'd3;
    dif.divisor  = 8'd0;

    // start held high: restarts every W+2 cycles
    @(negedge clk);
    wait_idle();
    dif.start    = 1'b1;
    dif.dividend = 8'd77;
    dif.divisor  = 8'd6;
    acc = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e.a = 8'd77;
      e.b = 8'd6;
      e.q = 8'd12;
      e.r = 8'd5;
      e.z = 1'b0;
      e.cyc = acc + W + k * (W + 2);
      e.nb = W;
      sb.push_back(e);
    end
    n = 0;
    while (cyc != acc + 2 * (W + 2) + 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("held_timeout", 1, 0);
    dif.start = 1'b0;

    // reset on the 4th busy cycle aborts the division
    div_op(8'd200, 8'd3, 8'd66, 8'd2);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("abort");
    sb.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    div_op(8'd200, 8'd3, 8'd66, 8'd2);

    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 19) == 0) ? '0 : W'($urandom);
      if (b == '0) div_op(a, b, '1, a);
      else div_op(a, b, a / b, a % b);
    end

    n = 0;
    while ((sb.size() != 0 || dif.busy || dif.done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
